muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the EX stage, beside the combinational ALU.
//  EX issues one op with operands through a start pulse.
//  The unit holds busy while computing, so hazard logic can stall IF/ID/EX.
//  It returns a registered result with a one-cycle done pulse.

---
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit for the EX stage.
// One product/quotient bit per clock, with a fast path for divide corner cases.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] m_q, m_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            sgn_a, sgn_b;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            b_zero, ovf;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rsh;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] hi_n, lo_n;
  logic [2*XLEN-1:0] prod, prod_f;
  logic [XLEN-1:0] quo_f, rem_f;
  logic [XLEN-1:0] fin;

  always_comb begin
    sgn_a  = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
             (op == 3'b100) || (op == 3'b110);
    sgn_b  = (op == 3'b000) || (op == 3'b001) ||
             (op == 3'b100) || (op == 3'b110);
    a_neg  = sgn_a & operand_a[XLEN-1];
    b_neg  = sgn_b & operand_b[XLEN-1];
    a_mag  = a_neg ? -operand_a : operand_a;
    b_mag  = b_neg ? -operand_b : operand_b;
    b_zero = op[2] && (operand_b == '0);
    ovf    = op[2] && !op[0] &&
             (operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
             (operand_b == '1);
  end

  // Shared datapath: hi/lo hold the partial product or remainder/quotient.
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    rsh  = {hi_q, lo_q[XLEN-1]};
    diff = rsh - {1'b0, m_q};
    ge   = !diff[XLEN];
    if (op_q[2]) begin
      hi_n = ge ? diff[XLEN-1:0] : rsh[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], ge};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo_q[XLEN-1:1]};
    end
    prod   = {hi_n, lo_n};
    prod_f = neg_q ? -prod : prod;
    quo_f  = neg_q ? -lo_n : lo_n;
    rem_f  = neg_q ? -hi_n : hi_n;
    if (op_q[2])
      fin = op_q[1] ? rem_f : quo_f;
    else if (op_q[1:0] == 2'b00)
      fin = prod_f[XLEN-1:0];
    else
      fin = prod_f[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start && !flush) begin
          op_d  = op;
          cnt_d = '0;
          hi_d  = '0;
          if (b_zero) begin
            state_d = DONE;
            res_d   = op[1] ? operand_a : '1;
          end else if (ovf) begin
            state_d = DONE;
            res_d   = op[1] ? '0 : operand_a;
          end else begin
            state_d = CALC;
            m_d     = op[2] ? b_mag : a_mag;
            lo_d    = op[2] ? a_mag : b_mag;
            neg_d   = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          hi_d  = hi_n;
          lo_d  = lo_n;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) begin
            state_d = DONE;
            res_d   = fin;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit.
// Checks result values, latency, busy/done framing, flush and reset.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int nchk;
  int nfail;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    string       name;
  } vec_t;

  vec_t vq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    operand_a = 32'hDEAD_BEEF;
    operand_b = 32'h0BAD_F00D;
  endtask

  // Waits for done starting in cycle 1; returns latency and busy errors.
  task automatic wait_done(output int lat, output int bad_busy);
    lat      = 1;
    bad_busy = 0;
    while (!done && lat < 40) begin
      if (busy !== 1'b1) bad_busy++;
      tick();
      lat++;
    end
    if (busy !== 1'b0) bad_busy++;
  endtask

  initial begin
    int lat;
    int bb;
    logic [31:0] held;

    nchk      = 0;
    nfail     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    flush     = 1'b0;
    op        = 3'b000;
    operand_a = '0;
    operand_b = '0;

    vq.push_back('{3'b000, 32'd7,        32'd6,        32'h0000002A, 33, "mul_7x6"});
    vq.push_back('{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, "mulh_m1"});
    vq.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max"});
    vq.push_back('{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, "mulhsu"});
    vq.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_m7_2"});
    vq.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_m7_2"});
    vq.push_back('{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu_by0"});
    vq.push_back('{3'b111, 32'd5,        32'd0,        32'h00000005, 1,  "remu_by0"});
    vq.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf"});
    vq.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "rem_ovf"});
    vq.push_back('{3'b000, 32'd0,        32'd5,        32'h00000000, 33, "mul_zero"});
    vq.push_back('{3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33, "mul_neg"});
    vq.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_min"});
    vq.push_back('{3'b101, 32'd100,      32'd7,        32'h0000000E, 33, "divu_100_7"});
    vq.push_back('{3'b111, 32'hFFFFFFFF, 32'd10,       32'h00000005, 33, "remu_max"});
    vq.push_back('{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "div_by0"});

    #12;
    chk("reset_busy",   {31'd0, busy},   32'd0);
    chk("reset_done",   {31'd0, done},   32'd0);
    chk("reset_result", result,          32'd0);
    rst_n = 1'b1;
    tick();

    foreach (vq[i]) begin
      issue(vq[i].op, vq[i].a, vq[i].b);
      wait_done(lat, bb);
      chk({vq[i].name, "_lat"},  lat,    vq[i].lat);
      chk({vq[i].name, "_res"},  result, vq[i].res);
      chk({vq[i].name, "_busy"}, bb,     32'd0);
      tick();
      chk({vq[i].name, "_done1"}, {31'd0, done}, 32'd0);
      tick();
    end

    // Flush mid-divide: no done, result kept.
    held = result;
    issue(3'b101, 32'd100, 32'd7);
    for (int c = 1; c < 10; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    bb = 0;
    for (int c = 0; c < 30; c++) begin
      if (done !== 1'b0) bb++;
      tick();
    end
    chk("flush_nodone", bb,     32'd0);
    chk("flush_result", result, held);

    issue(3'b111, 32'd100, 32'd7);
    wait_done(lat, bb);
    chk("remu_after_lat", lat,    32'd33);
    chk("remu_after_res", result, 32'd2);
    tick();

    // Back-to-back: new start on the done cycle.
    issue(3'b000, 32'd7, 32'd6);
    wait_done(lat, bb);
    chk("b2b_first_res", result, 32'h2A);
    issue(3'b000, 32'd3, 32'd3);
    chk("b2b_done_drop", {31'd0, done}, 32'd0);
    chk("b2b_busy",      {31'd0, busy}, 32'd1);
    wait_done(lat, bb);
    chk("b2b_lat", lat,    32'd33);
    chk("b2b_res", result, 32'd9);

    // Flush and start on the done cycle: start dropped.
    tick();
    issue(3'b101, 32'd5, 32'd0);
    chk("fs_done", {31'd0, done}, 32'd1);
    op    = 3'b000;
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    chk("fs_busy", {31'd0, busy}, 32'd0);
    chk("fs_done_drop", {31'd0, done}, 32'd0);
    chk("fs_result", result, 32'hFFFFFFFF);

    // Start during CALC is ignored.
    tick();
    issue(3'b000, 32'd4, 32'd5);
    for (int c = 1; c < 5; c++) tick();
    op        = 3'b101;
    operand_a = 32'd9;
    operand_b = 32'd0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chk("calc_ign_busy", {31'd0, busy}, 32'd1);
    lat = 6;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk("calc_ign_lat", lat,    32'd33);
    chk("calc_ign_res", result, 32'd20);

    // Asynchronous reset mid-multiply.
    tick();
    tick();
    issue(3'b000, 32'd7, 32'd6);
    for (int c = 1; c < 5; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",   {31'd0, busy}, 32'd0);
    chk("arst_done",   {31'd0, done}, 32'd0);
    chk("arst_result", result,        32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_idle", {31'd0, busy | done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
